// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control front end: FSM states, BCD time word
// and digit field offsets inside that word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } sw_state_e;

  // {MIN, TENSEC, SEC, DECISEC, CENTISEC}, one BCD nibble each
  typedef logic [19:0] bcd_time_t;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned CENTISEC_LSB = 0;
  localparam int unsigned DECISEC_LSB  = 4;
  localparam int unsigned SEC_LSB      = 8;
  localparam int unsigned TENSEC_LSB   = 12;
  localparam int unsigned MIN_LSB      = 16;

endpackage

// File: rtl/btn_sync_edge.sv
// Raw button -> one-cycle press pulse: 2-flop synchronizer, optional debounce
// (compiled in with STOPWATCH_DEBOUNCE_EN), rising-edge detect.
module btn_sync_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // Count consecutive cycles the synchronized level differs from the accepted one.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync_q[1];
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
  assign level           = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level;
  end

  assign press_o = level & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button FSM, 10 ms tick prescaler and lap-freeze display.
// Define STOPWATCH_DEBOUNCE_EN to add button debouncing inside btn_sync_edge.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic      CLK,
  input  logic      RESET_N,
  input  logic      BTN_START,
  input  logic      BTN_LAP,
  input  bcd_time_t TIME,
  output logic      SW_ENABLE,
  output logic      SW_CLEAR,
  output bcd_time_t DISP_TIME,
  output logic      RUNNING,
  output logic      LAPPED
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             start_p, lap_p, lap_go;
  sw_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  bcd_time_t        lap_q, lap_d;
  logic             en_q, en_d;
  logic             clr_q, clr_d;
  logic             counting;

  btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(CLK), .rst_n(RESET_N), .btn_i(BTN_START), .press_o(start_p)
  );

  btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(CLK), .rst_n(RESET_N), .btn_i(BTN_LAP), .press_o(lap_p)
  );

  // Start has priority: a lap press in the same cycle is dropped.
  assign lap_go   = lap_p & ~start_p;
  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_p)     state_d = ST_RUN;
        else if (lap_go) clr_d   = 1'b1;
      end
      ST_RUN: begin
        if (start_p) state_d = ST_STOP;
        else if (lap_go) begin
          state_d = ST_LAP;
          lap_d   = TIME;
        end
      end
      ST_LAP: begin
        if (start_p)     state_d = ST_STOP;
        else if (lap_go) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (start_p) state_d = ST_RUN;
        else if (lap_go) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // STOP holds the prescaler so a pause keeps the sub-tick fraction.
  always_comb begin
    pre_d = pre_q;
    if (state_q == ST_IDLE) pre_d = '0;
    else if (counting)      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
  end

  assign en_d = counting && (pre_q == PRE_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      lap_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lap_q   <= lap_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  assign SW_ENABLE = en_q;
  assign SW_CLEAR  = clr_q;
  assign RUNNING   = counting;
  assign LAPPED    = (state_q == ST_LAP);
  assign DISP_TIME = (state_q == ST_LAP) ? lap_q : TIME;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a TICK_DIV=4 instance driving a BCD
// counter model, plus a TICK_DIV=1 instance for the every-cycle tick case.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DEB = 5;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = LAT + 3;

  typedef enum logic {DM_LIVE, DM_VALUE} disp_mode_e;
  typedef struct {
    int         cyc;
    logic       run;
    logic       lap;
    disp_mode_e dm;
    logic [19:0] dv;
  } st_ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start, btn_lap, btn1_start;
  logic [19:0] tm;
  logic        pre_req;
  logic [19:0] pre_val;
  logic        en4, clr4, run4, lap4;
  logic [19:0] disp4;
  logic        en1, clr1, run1, lap1;
  logic [19:0] disp1;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  logic   mon_en = 1'b0;
  logic   prev_run = 1'b0, prev_lap = 1'b0;
  st_ev_t st_q[$];
  int     en_q[$];
  int     clr_q[$];
  st_ev_t mon_ev;
  int     mon_c;
  int     press_cyc;
  int     c1, s1, r, l1, l2, s2, cc, cc2, c3, tmp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK(clk), .RESET_N(rst_n), .BTN_START(btn_start), .BTN_LAP(btn_lap),
    .TIME(tm), .SW_ENABLE(en4), .SW_CLEAR(clr4), .DISP_TIME(disp4),
    .RUNNING(run4), .LAPPED(lap4)
  );

  stopwatch_ctrl #(.TICK_DIV(1), .DEBOUNCE_CYCLES(DEB)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .BTN_START(btn1_start), .BTN_LAP(1'b0),
    .TIME(20'h00000), .SW_ENABLE(en1), .SW_CLEAR(clr1), .DISP_TIME(disp1),
    .RUNNING(run1), .LAPPED(lap1)
  );

  function automatic logic [19:0] bcd_inc(input logic [19:0] t);
    logic [19:0] v;
    logic        carry;
    logic [3:0]  lim;
    v     = t;
    carry = 1'b1;
    for (int d = 0; d < 5; d++) begin
      lim = (d * DIGIT_W == TENSEC_LSB) ? 4'd5 : 4'd9;
      if (carry) begin
        if (v[d*DIGIT_W +: DIGIT_W] == lim) v[d*DIGIT_W +: DIGIT_W] = 4'd0;
        else begin
          v[d*DIGIT_W +: DIGIT_W] = v[d*DIGIT_W +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return v;
  endfunction

  // Stopwatch counter the block controls; preload lets the bench jump TIME.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tm <= 20'h00000;
    else if (clr4)    tm <= 20'h00000;
    else if (pre_req) tm <= pre_val;
    else if (en4)     tm <= bcd_inc(tm);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output event at cycle %0d", name, cyc);
  endtask

  // Monitor: any visible output event pops the matching expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (run4 !== prev_run || lap4 !== prev_lap) begin
        if (st_q.size() == 0) unexpected("state");
        else begin
          mon_ev = st_q.pop_front();
          check("state_cycle", cyc, mon_ev.cyc);
          check("state_running", {31'd0, run4}, {31'd0, mon_ev.run});
          check("state_lapped", {31'd0, lap4}, {31'd0, mon_ev.lap});
          if (mon_ev.dm == DM_VALUE) check("state_disp", {12'd0, disp4}, {12'd0, mon_ev.dv});
          else                       check("state_disp_live", {12'd0, disp4}, {12'd0, tm});
        end
        prev_run = run4;
        prev_lap = lap4;
      end
      if (en4) begin
        if (en_q.size() == 0) unexpected("sw_enable");
        else begin
          mon_c = en_q.pop_front();
          check("enable_cycle", cyc, mon_c);
          check("enable_clear_excl", {31'd0, clr4}, 32'd0);
        end
      end
      if (clr4) begin
        if (clr_q.size() == 0) unexpected("sw_clear");
        else begin
          mon_c = clr_q.pop_front();
          check("clear_cycle", cyc, mon_c);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    if (cyc > t) begin
      checks++;
      errors++;
      $display("FAIL schedule: at cycle %0d, required at most %0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge: the raw edge meets setup before edge cyc+1.
  task automatic begin_press(input logic s, input logic l, output int chg);
    if (s) btn_start = 1'b1;
    if (l) btn_lap   = 1'b1;
    press_cyc = cyc;
    chg       = cyc + 1 + LAT;
  endtask

  task automatic finish_press();
    while (cyc < press_cyc + HOLD) @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic push_state(input int c, input logic run, input logic lap,
                            input disp_mode_e dm, input logic [19:0] dv);
    st_ev_t e;
    e.cyc = c; e.run = run; e.lap = lap; e.dm = dm; e.dv = dv;
    st_q.push_back(e);
  endtask

  task automatic push_en(input int first, input int last);
    for (int e = first; e <= last; e += 4) en_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    btn_start = 1'b0; btn_lap = 1'b0; btn1_start = 1'b0;
    pre_req = 1'b0; pre_val = 20'h00000; rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_clear", {31'd0, clr4}, 32'd1);
    check("rst_enable", {31'd0, en4}, 32'd0);
    check("rst_running", {31'd0, run4}, 32'd0);
    check("rst_lapped", {31'd0, lap4}, 32'd0);
    check("rst_disp", {12'd0, disp4}, 32'h00000);
    check("rst1_clear", {31'd0, clr1}, 32'd1);

    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("clear_held_after_release", {31'd0, clr4}, 32'd1);
    @(negedge clk);
    check("clear_drops", {31'd0, clr4}, 32'd0);
    check("idle_after_reset", {31'd0, run4}, 32'd0);
    check("rst1_clear_drops", {31'd0, clr1}, 32'd0);
    check("rst1_enable", {31'd0, en1}, 32'd0);
    mon_en = 1'b1;

    // TICK_DIV=1: enable every cycle while running, starting one edge after RUN.
    btn1_start = 1'b1;
    tmp = cyc + 1 + LAT;
    wait_until(tmp);
    check("div1_running", {31'd0, run1}, 32'd1);
    check("div1_no_enable_yet", {31'd0, en1}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("div1_enable", {31'd0, en1}, 32'd1);
      check("div1_clear", {31'd0, clr1}, 32'd0);
    end
    btn1_start = 1'b0;
    repeat (HOLD) @(negedge clk);

    // Start from IDLE; ticks every 4th edge; stop when the prescaler reaches 2.
    begin_press(1'b1, 1'b0, c1);
    s1 = c1 + 46;
    push_state(c1, 1'b1, 1'b0, DM_LIVE, 20'h0);
    push_en(c1 + 4, c1 + 44);
    push_state(s1, 1'b0, 1'b0, DM_LIVE, 20'h0);
    finish_press();
    wait_until(c1 + 33);
    check("time_after_8_ticks", {12'd0, tm}, 32'h00008);
    wait_until(s1 - 1 - LAT);
    begin_press(1'b1, 1'b0, tmp);
    finish_press();
    repeat (8) @(negedge clk);
    check("time_held_in_stop", {12'd0, tm}, 32'h00011);

    // Resume (prescaler 2 -> 3, tick two edges later), lap freeze, unfreeze,
    // then simultaneous start+lap stops without capturing.
    begin_press(1'b1, 1'b0, r);
    l1 = r + 29;
    l2 = r + 57;
    s2 = r + 81;
    push_state(r, 1'b1, 1'b0, DM_LIVE, 20'h0);
    push_state(l1, 1'b1, 1'b1, DM_VALUE, 20'h00123);
    push_state(l2, 1'b1, 1'b0, DM_LIVE, 20'h0);
    push_state(s2, 1'b0, 1'b0, DM_LIVE, 20'h0);
    push_en(r + 2, s2);
    finish_press();

    wait_until(l1 - 1 - LAT);
    begin_press(1'b0, 1'b1, tmp);
    wait_until(r + 27);
    pre_val = 20'h00123;
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
    finish_press();
    check("lap_disp_frozen", {12'd0, disp4}, 32'h00123);
    check("lap_time_moves_on", {31'd0, (tm == 20'h00123)}, 32'd0);
    check("lapped_high", {31'd0, lap4}, 32'd1);

    wait_until(l2 - 1 - LAT);
    begin_press(1'b0, 1'b1, tmp);
    finish_press();
    check("disp_live_again", {12'd0, disp4}, {12'd0, tm});
    check("lapped_low", {31'd0, lap4}, 32'd0);

    wait_until(s2 - 1 - LAT);
    begin_press(1'b1, 1'b1, tmp);
    finish_press();
    check("both_running_low", {31'd0, run4}, 32'd0);
    check("both_no_lap", {31'd0, lap4}, 32'd0);

    // Lap in STOP clears once and returns to IDLE; lap in IDLE clears again.
    begin_press(1'b0, 1'b1, cc);
    clr_q.push_back(cc);
    finish_press();
    check("counter_cleared", {12'd0, tm}, 32'h00000);
    begin_press(1'b0, 1'b1, cc2);
    clr_q.push_back(cc2);
    finish_press();
    check("idle_lap_time", {12'd0, tm}, 32'h00000);
    check("idle_lap_running", {31'd0, run4}, 32'd0);

`ifdef STOPWATCH_DEBOUNCE_EN
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_ignored", {31'd0, run4}, 32'd0);
`endif

    // Prescaler was forced to 0 in IDLE: first tick TICK_DIV edges after RUN.
    begin_press(1'b1, 1'b0, c3);
    push_state(c3, 1'b1, 1'b0, DM_LIVE, 20'h0);
    push_en(c3 + 4, c3 + 16);
    finish_press();
    wait_until(c3 + 16);
    #1;
    mon_en = 1'b0;
    check("time_after_restart", {12'd0, tm}, 32'h00003);
    check("state_events_left", st_q.size(), 32'd0);
    check("enable_events_left", en_q.size(), 32'd0);
    check("clear_events_left", clr_q.size(), 32'd0);

    // Mid-operation reset while a tick is high.
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_clear", {31'd0, clr4}, 32'd1);
    check("midrst_enable", {31'd0, en4}, 32'd0);
    check("midrst_running", {31'd0, run4}, 32'd0);
    check("midrst_lapped", {31'd0, lap4}, 32'd0);
    check("midrst_disp", {12'd0, disp4}, 32'h00000);
    check("midrst1_enable", {31'd0, en1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
